load_store_unit: RTL and testbench

Initiator side of the single-cycle data memory interface. It accepts byte, halfword and word load/store requests from the CPU datapath, issues word-wide MemRead/MemWrite strobes to the 128×32 data memory, and returns load data to the requester. Loads are sign- or zero-extended. Sub-word stores use read-modify-write. Misaligned or reserved-size requests are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit and its lane aligner.
package lsu_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsuSizeT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP,
    ST_ERR
  } lsuStateT;

  // A request is rejected for the reserved size or a misaligned half/word.
  function automatic logic isBadRequest(input lsuSizeT size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian word:
// extracts and extends load data, and merges store data into a read word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        offset,
  input  lsuSizeT           size,
  input  logic              isSigned,
  input  logic [DATA_W-1:0] readWord,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadValue,
  output logic [DATA_W-1:0] mergedWord
);

  localparam int LANES = 4;

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  assign selByte = readWord[{offset, 3'b000} +: 8];
  assign selHalf = offset[1] ? readWord[31:16] : readWord[15:0];

  // Right-justify the selected lane, then sign- or zero-extend it.
  always_comb begin
    loadValue = readWord;
    case (size)
      SZ_BYTE: loadValue = {{(DATA_W-8){isSigned & selByte[7]}}, selByte};
      SZ_HALF: loadValue = {{(DATA_W-16){isSigned & selHalf[15]}}, selHalf};
      default: loadValue = readWord;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);
      logic       laneHit;
      logic [7:0] laneData;

      // Decide whether this lane is overwritten and with which store byte.
      always_comb begin
        laneHit  = 1'b0;
        laneData = storeData[8*gi +: 8];
        case (size)
          SZ_BYTE: begin
            laneHit  = (offset == LANE);
            laneData = storeData[7:0];
          end
          SZ_HALF: begin
            laneHit  = (offset[1] == LANE[1]);
            laneData = storeData[8*(gi%2) +: 8];
          end
          SZ_WORD: laneHit = 1'b1;
          default: laneHit = 1'b0;
        endcase
      end

      assign mergedWord[8*gi +: 8] = laneHit ? laneData : readWord[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Initiator for a single-cycle word memory: byte/half/word loads and stores,
// sub-word stores by read-modify-write, bad requests answered without memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W+1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic              RespError,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  lsuStateT          stateReg, stateNext;
  logic              readyReg;
  logic              writeReg;
  lsuSizeT           sizeReg;
  logic              signedReg;
  logic [1:0]        offsetReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] storeReg;
  logic [DATA_W-1:0] loadReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] laneLoad;
  logic [DATA_W-1:0] laneMerge;
  logic              accept;

  // readyReg is only ever set while the FSM sits in IDLE.
  assign accept       = ReqValid & readyReg;
  assign ReqReady     = readyReg;
  assign MemAddress   = addrReg;
  assign MemWriteData = wdataReg;

  // The aligner only matters in CAPTURE, when MemReadData holds the addressed word.
  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) uLaneAlign (
    .offset    (offsetReg),
    .size      (sizeReg),
    .isSigned  (signedReg),
    .readWord  (MemReadData),
    .storeData (storeReg),
    .loadValue (laneLoad),
    .mergedWord(laneMerge)
  );

  // State, request latches and the data words presented to memory/requester.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateReg  <= ST_IDLE;
      readyReg  <= 1'b0;
      writeReg  <= 1'b0;
      sizeReg   <= SZ_BYTE;
      signedReg <= 1'b0;
      offsetReg <= 2'b00;
      addrReg   <= '0;
      storeReg  <= '0;
      loadReg   <= '0;
      wdataReg  <= '0;
    end else begin
      stateReg <= stateNext;
      readyReg <= (stateNext == ST_IDLE);
      if (accept) begin
        writeReg  <= ReqWrite;
        sizeReg   <= lsuSizeT'(ReqSize);
        signedReg <= ReqSigned;
        offsetReg <= ReqAddr[1:0];
        addrReg   <= ReqAddr[ADDR_W+1:2];
        storeReg  <= ReqData;
        // A word store skips the read, so its write word is ready now.
        if (ReqWrite && ReqSize == SZ_WORD) begin
          wdataReg <= ReqData;
        end
      end
      if (stateReg == ST_CAPTURE) begin
        loadReg <= laneLoad;
        if (writeReg) begin
          wdataReg <= laneMerge;
        end
      end
    end
  end

  // Next-state decode; every output below depends on stateReg only.
  always_comb begin
    stateNext = stateReg;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RespValid = 1'b0;
    RespError = 1'b0;
    RespData  = '0;
    case (stateReg)
      ST_IDLE: begin
        if (accept) begin
          if (isBadRequest(lsuSizeT'(ReqSize), ReqAddr[1:0])) begin
            stateNext = ST_ERR;
          end else if (ReqWrite && ReqSize == SZ_WORD) begin
            stateNext = ST_WRITE;
          end else begin
            stateNext = ST_READ;
          end
        end
      end
      ST_READ: begin
        MemRead   = 1'b1;
        stateNext = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        stateNext = writeReg ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        MemWrite  = 1'b1;
        stateNext = ST_RESP;
      end
      ST_RESP: begin
        RespValid = 1'b1;
        RespData  = writeReg ? '0 : loadReg;
        stateNext = ST_IDLE;
      end
      ST_ERR: begin
        RespValid = 1'b1;
        RespError = 1'b1;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 128x32 registered-read memory model.
module tb_load_store_unit;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [1:0]    ReqSize;
  logic          ReqSigned;
  logic [AW+1:0] ReqAddr;
  logic [DW-1:0] ReqData;
  logic          RespValid;
  logic [DW-1:0] RespData;
  logic          RespError;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] MemReadData;

  logic [DW-1:0] memArray [0:127];
  logic [DW-1:0] memRdataReg = '0;

  int checkCount = 0;
  int errorCount = 0;
  int overlapCount = 0;

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqWrite    (ReqWrite),
    .ReqSize     (ReqSize),
    .ReqSigned   (ReqSigned),
    .ReqAddr     (ReqAddr),
    .ReqData     (ReqData),
    .RespValid   (RespValid),
    .RespData    (RespData),
    .RespError   (RespError),
    .MemAddress  (MemAddress),
    .MemWriteData(MemWriteData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemReadData (MemReadData)
  );

  always #5 Clk = ~Clk;

  // Memory model: read data appears the cycle after MemRead.
  always @(posedge Clk) begin
    if (MemRead) memRdataReg <= memArray[MemAddress];
    if (MemWrite) memArray[MemAddress] <= MemWriteData;
  end
  assign MemReadData = memRdataReg;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request (called at a negedge) and check its whole transaction.
  task automatic runReq(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [8:0] addr, input logic [31:0] data,
                        input logic [31:0] expData, input logic expErr, input int expLat,
                        input int expRd, input int expWr, input logic [31:0] expWdata,
                        input logic [6:0] expMaddr);
    int lat = 0;
    int rdCnt = 0;
    int wrCnt = 0;
    int rdCycle = 0;
    int wrCycle = 0;
    int guard = 0;
    logic [31:0] wdata = '0;
    logic [6:0] rdAddr = '0;
    logic [6:0] wrAddr = '0;
    logic [31:0] rData = '0;
    logic rErr = 1'b0;
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = size; ReqSigned = sgn; ReqAddr = addr; ReqData = data;
    while (!ReqReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    checkValue({tag, "_ready"}, 32'(ReqReady), 32'd1);
    @(posedge Clk);
    #1;
    ReqValid = 1'b0; ReqData = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      if (MemRead && MemWrite) overlapCount++;
      if (MemRead) begin rdCnt++; rdCycle = n; rdAddr = MemAddress; end
      if (MemWrite) begin wrCnt++; wrCycle = n; wdata = MemWriteData; wrAddr = MemAddress; end
      if (RespValid) begin lat = n; rData = RespData; rErr = RespError; break; end
    end
    $display("txn %s lat=%0d data=0x%08h err=%0b rd=%0d wr=%0d", tag, lat, rData, rErr, rdCnt, wrCnt);
    checkValue({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkValue({tag, "_data"}, rData, expData);
    checkValue({tag, "_err"}, 32'(rErr), 32'(expErr));
    checkValue({tag, "_rdcnt"}, 32'(rdCnt), 32'(expRd));
    checkValue({tag, "_wrcnt"}, 32'(wrCnt), 32'(expWr));
    if (expRd > 0) begin
      checkValue({tag, "_rdcyc"}, 32'(rdCycle), 32'd1);
      checkValue({tag, "_rdaddr"}, 32'(rdAddr), 32'(expMaddr));
    end
    if (expWr > 0) begin
      checkValue({tag, "_wrcyc"}, 32'(wrCycle), 32'(expLat - 1));
      checkValue({tag, "_wraddr"}, 32'(wrAddr), 32'(expMaddr));
      checkValue({tag, "_wdata"}, wdata, expWdata);
    end
    @(negedge Clk);
    checkValue({tag, "_b2b_ready"}, 32'(ReqReady), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int badCnt;
    for (int i = 0; i < 128; i++) memArray[i] = '0;
    memArray[5] = 32'hA1B2C3D4;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = '0; ReqData = '0;

    #2;
    checkValue("rst_ready", 32'(ReqReady), 32'd0);
    checkValue("rst_respvalid", 32'(RespValid), 32'd0);
    checkValue("rst_respdata", RespData, 32'd0);
    checkValue("rst_resperror", 32'(RespError), 32'd0);
    checkValue("rst_memread", 32'(MemRead), 32'd0);
    checkValue("rst_memwrite", 32'(MemWrite), 32'd0);
    checkValue("rst_memaddr", 32'(MemAddress), 32'd0);
    checkValue("rst_memwdata", MemWriteData, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkValue("ready_before_edge", 32'(ReqReady), 32'd0);
    @(negedge Clk);
    checkValue("ready_after_edge", 32'(ReqReady), 32'd1);

    //     tag          wr    size   sgn  addr    data           expData        err lat rd wr expWdata       maddr
    runReq("lb_s_17",   1'b0, 2'b00, 1'b1, 9'h017, 32'h0,        32'hFFFFFFA1, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("lh_u_16",   1'b0, 2'b01, 1'b0, 9'h016, 32'h0,        32'h0000A1B2, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("lh_s_14",   1'b0, 2'b01, 1'b1, 9'h014, 32'h0,        32'hFFFFC3D4, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("lb_u_14",   1'b0, 2'b00, 1'b0, 9'h014, 32'h0,        32'h000000D4, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("sb_15",     1'b1, 2'b00, 1'b0, 9'h015, 32'h000000EE, 32'h0,        1'b0, 4, 1, 1, 32'hA1B2EED4, 7'd5);
    runReq("lw_14",     1'b0, 2'b10, 1'b1, 9'h014, 32'h0,        32'hA1B2EED4, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("sw_20",     1'b1, 2'b10, 1'b0, 9'h020, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 7'd8);
    runReq("lw_20",     1'b0, 2'b10, 1'b0, 9'h020, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0,        7'd8);
    runReq("lw_16_err", 1'b0, 2'b10, 1'b0, 9'h016, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        7'd0);
    runReq("rsvd_st",   1'b1, 2'b11, 1'b0, 9'h014, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0,        7'd0);
    runReq("rsvd_ld",   1'b0, 2'b11, 1'b1, 9'h014, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        7'd0);
    runReq("lh_15_err", 1'b0, 2'b01, 1'b1, 9'h015, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        7'd0);
    runReq("sh_16",     1'b1, 2'b01, 1'b0, 9'h016, 32'hFFFF1234, 32'h0,        1'b0, 4, 1, 1, 32'h1234EED4, 7'd5);
    runReq("lh_s_16",   1'b0, 2'b01, 1'b1, 9'h016, 32'h0,        32'h00001234, 1'b0, 3, 1, 0, 32'h0,        7'd5);
    runReq("sb_17",     1'b1, 2'b00, 1'b0, 9'h017, 32'hAAAAAA80, 32'h0,        1'b0, 4, 1, 1, 32'h8034EED4, 7'd5);
    runReq("lb_s_17b",  1'b0, 2'b00, 1'b1, 9'h017, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0,        7'd5);

    // Reset during CAPTURE of a byte store: no write, no response.
    memArray[5] = 32'hA1B2C3D4;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = 9'h015; ReqData = 32'hEE;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    @(negedge Clk);
    checkValue("rstmid_read", 32'(MemRead), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checkValue("rstmid_memread", 32'(MemRead), 32'd0);
    checkValue("rstmid_memwrite", 32'(MemWrite), 32'd0);
    badCnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge Clk);
      if (MemWrite || RespValid || ReqReady) badCnt++;
    end
    Rst_n = 1'b1;
    #1;
    checkValue("rstmid_ready_pre", 32'(ReqReady), 32'd0);
    @(negedge Clk);
    checkValue("rstmid_ready_post", 32'(ReqReady), 32'd1);
    for (int n = 0; n < 4; n++) begin
      if (MemWrite || RespValid || MemRead) badCnt++;
      @(negedge Clk);
    end
    $display("txn rstmid bad_activity=%0d mem5=0x%08h", badCnt, memArray[5]);
    checkValue("rstmid_activity", 32'(badCnt), 32'd0);
    checkValue("rstmid_mem5", memArray[5], 32'hA1B2C3D4);
    checkValue("strobe_overlap", 32'(overlapCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
